// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - Q8.24 fixed-point vector types, saturating helpers and screen constants
package vector_pkg;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    localparam fp FP_ONE = 32'sh0100_0000;
    localparam fp FP_MAX = 32'sh7fff_ffff;
    localparam fp FP_MIN = 32'sh8000_0000;

    function automatic fp fp_sat(input logic signed [63:0] a);
        if (a > 64'sh0000_0000_7fff_ffff) begin
            return FP_MAX;
        end else if (a < -64'sh0000_0000_8000_0000) begin
            return FP_MIN;
        end
        return fp'(a);
    endfunction

    function automatic fp fp_add(input fp a, input fp b);
        return fp_sat(64'(a) + 64'(b));
    endfunction

    function automatic fp fp_sub(input fp a, input fp b);
        return fp_sat(64'(a) - 64'(b));
    endfunction

    function automatic fp fp_mul(input fp a, input fp b);
        return fp_sat((64'(a) * 64'(b)) >>> 24);
    endfunction

    // 2/pixels in Q8.24, rounded to nearest
    function automatic fp pixel_scale(input int pixels);
        longint q;
        q = ((longint'(1) << 25) + longint'(pixels / 2)) / longint'(pixels);
        return fp'(q);
    endfunction

    function automatic fp aspect_ratio(input int width, input int height);
        longint q;
        q = ((longint'(width) << 24) + longint'(height / 2)) / longint'(height);
        return fp'(q);
    endfunction

endpackage

// File: rtl/fp_inv_sqrt.sv
// rtl/fp_inv_sqrt.sv - 4-stage pipelined 1/sqrt of an unsigned Q16.48 value, Q24.24 result
module fp_inv_sqrt (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] sum_sq,
    output logic [47:0] inv_root
);

    // Seed = 1/sqrt of the bucket centre (i + 0.5)/16, in Q16; buckets below 1.0 never occur.
    function automatic logic [16:0] seed_val(input int idx);
        logic [63:0] n;
        logic [16:0] root;
        logic [16:0] trial;
        if (idx < 16) begin
            return 17'h1_0000;
        end
        n    = (64'd1 << 37) / 64'(2 * idx + 1);
        root = '0;
        for (int b = 16; b >= 0; b--) begin
            trial = root | (17'd1 << b);
            if (64'(trial) * 64'(trial) <= n) begin
                root = trial;
            end
        end
        return root;
    endfunction

    // One Newton-Raphson step y' = y * (3 - m*y^2) / 2, all operands Q30
    function automatic logic [31:0] nr_step(input logic [31:0] y, input logic [31:0] m);
        logic [63:0] t;
        logic [63:0] p;
        logic [63:0] h;
        logic [63:0] yn;
        t  = (64'(y) * 64'(y)) >> 30;
        p  = (t * 64'(m)) >> 30;
        h  = (64'd3 << 30) - p;
        yn = (64'(y) * h) >> 31;
        return yn[31:0];
    endfunction

    logic [63:0][16:0] seed_lut;

    for (genvar g = 0; g < 64; g++) begin : g_seed
        assign seed_lut[g] = seed_val(g);
    end

    logic [6:0]  lz;
    logic [5:0]  k;
    logic [31:0] m_q30;
    logic [31:0] y0;

    // Even-shift normalise so the mantissa lands in [1,4) and the exponent halves exactly
    always_comb begin
        lz = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (sum_sq[i]) begin
                lz = 7'(63 - i);
            end
        end
        k     = 6'(lz >> 1);
        m_q30 = 32'((sum_sq << {k, 1'b0}) >> 32);
        y0    = {1'b0, seed_lut[m_q30[31:26]], 14'd0};
    end

    logic [31:0] s1_m, s1_y, s2_m, s2_y, s3_y;
    logic [5:0]  s1_k, s2_k, s3_k;
    logic [63:0] wide;
    logic [63:0] scaled;
    logic [47:0] root_next;

    // Result = y * 2^(k-7) in Q24, i.e. the Q30 mantissa shifted by k-13
    always_comb begin
        wide = {32'd0, s3_y};
        if (s3_k >= 6'd13) begin
            scaled = wide << (s3_k - 6'd13);
        end else begin
            scaled = wide >> (6'd13 - s3_k);
        end
        root_next = (scaled[63:48] != 16'd0) ? '1 : scaled[47:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_m     <= '0;
            s1_y     <= '0;
            s1_k     <= '0;
            s2_m     <= '0;
            s2_y     <= '0;
            s2_k     <= '0;
            s3_y     <= '0;
            s3_k     <= '0;
            inv_root <= '0;
        end else begin
            s1_m     <= m_q30;
            s1_y     <= y0;
            s1_k     <= k;
            s2_m     <= s1_m;
            s2_y     <= nr_step(s1_y, s1_m);
            s2_k     <= s1_k;
            s3_y     <= nr_step(s2_y, s2_m);
            s3_k     <= s2_k;
            inv_root <= root_next;
        end
    end

endmodule

// File: rtl/ray_generator.sv
// rtl/ray_generator.sv - pixel coordinate to unit primary-ray direction, 8-cycle pipeline
module ray_generator
    import vector_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] screen_x,
    input  logic [31:0] screen_y,
    input  logic        valid_in,
    input  vec3         camera_forward,
    output vec3         ray_direction,
    output logic        valid_out
);

    localparam fp SCALE_X = pixel_scale(SCREEN_WIDTH);
    localparam fp SCALE_Y = pixel_scale(SCREEN_HEIGHT);
    localparam fp ASPECT  = aspect_ratio(SCREEN_WIDTH, SCREEN_HEIGHT);
    localparam logic [63:0] DEGEN_LIMIT = 64'd1 << 28;

    function automatic logic [63:0] square(input fp a);
        logic signed [63:0] p;
        p = 64'(a) * 64'(a);
        return p;
    endfunction

    logic signed [63:0] prod_x, prod_y;

    always_comb begin
        prod_x = $signed({32'd0, screen_x}) * 64'(SCALE_X);
        prod_y = $signed({32'd0, screen_y}) * 64'(SCALE_Y);
    end

    logic s1_valid, s2_valid, s3_valid;
    fp    s1_nx, s1_ny, s2_u, s2_v;
    vec3  s1_fwd, s2_fwd, s3_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_nx    <= '0;
            s1_ny    <= '0;
            s1_fwd   <= '0;
            s2_valid <= 1'b0;
            s2_u     <= '0;
            s2_v     <= '0;
            s2_fwd   <= '0;
            s3_valid <= 1'b0;
            s3_d     <= '0;
        end else begin
            s1_valid <= valid_in;
            s1_nx    <= fp_sat(prod_x >>> 21);
            s1_ny    <= fp_sat(prod_y >>> 21);
            s1_fwd   <= camera_forward;
            s2_valid <= s1_valid;
            s2_u     <= fp_mul(fp_sub(s1_nx, FP_ONE), ASPECT);
            s2_v     <= fp_sub(FP_ONE, s1_ny);
            s2_fwd   <= s1_fwd;
            s3_valid <= s2_valid;
            s3_d.x   <= fp_add(s2_u, s2_fwd.x);
            s3_d.y   <= fp_add(s2_v, s2_fwd.y);
            s3_d.z   <= s2_fwd.z;
        end
    end

    // Squares and their sum feed the inverse-root front end directly so the whole path is 8 deep
    logic [63:0] sum_sq;
    logic        degenerate;
    logic [47:0] inv_root;

    always_comb begin
        sum_sq     = square(s3_d.x) + square(s3_d.y) + square(s3_d.z);
        degenerate = (sum_sq < DEGEN_LIMIT);
    end

    fp_inv_sqrt u_inv_sqrt (
        .clk      (clk),
        .rst      (rst),
        .sum_sq   (sum_sq),
        .inv_root (inv_root)
    );

    vec3 [3:0]  d_pipe;
    logic [3:0] valid_pipe;
    logic [3:0] degen_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_pipe     <= '0;
            valid_pipe <= '0;
            degen_pipe <= '0;
        end else begin
            d_pipe     <= {d_pipe[2:0], s3_d};
            valid_pipe <= {valid_pipe[2:0], s3_valid};
            degen_pipe <= {degen_pipe[2:0], degenerate};
        end
    end

    logic signed [63:0] root_s;
    vec3                normalized;

    always_comb begin
        root_s       = $signed({16'd0, inv_root});
        normalized.x = fp_sat((64'(d_pipe[3].x) * root_s) >>> 24);
        normalized.y = fp_sat((64'(d_pipe[3].y) * root_s) >>> 24);
        normalized.z = fp_sat((64'(d_pipe[3].z) * root_s) >>> 24);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ray_direction <= '0;
            valid_out     <= 1'b0;
        end else begin
            valid_out <= valid_pipe[3];
            if (valid_pipe[3]) begin
                ray_direction <= degen_pipe[3] ? {32'sd0, 32'sd0, FP_ONE} : normalized;
            end
        end
    end

endmodule

// File: tb/tb_ray_generator.sv
// tb/tb_ray_generator.sv - directed self-checking bench for ray_generator
module tb_ray_generator;
    import vector_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] screen_x = '0;
    logic [31:0] screen_y = '0;
    logic        valid_in = 1'b0;
    vec3         camera_forward = '0;
    vec3         ray_direction;
    logic        valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] vx [9];
    logic [31:0] vy [9];
    vec3         vf [9];
    real         ex [9];
    real         ey [9];
    real         ez [9];

    always #5 clk = ~clk;

    ray_generator #(
        .SCREEN_WIDTH  (640),
        .SCREEN_HEIGHT (480)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .screen_x       (screen_x),
        .screen_y       (screen_y),
        .valid_in       (valid_in),
        .camera_forward (camera_forward),
        .ray_direction  (ray_direction),
        .valid_out      (valid_out)
    );

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic longint q24(input real r);
        return longint'($rtoi(r * 16777216.0));
    endfunction

    function automatic vec3 mk_vec(input fp x, input fp y, input fp z);
        return {x, y, z};
    endfunction

    task automatic set_vec(input int i, input logic [31:0] sx, input logic [31:0] sy, input vec3 f,
                           input real rx, input real ry, input real rz);
        vx[i] = sx;
        vy[i] = sy;
        vf[i] = f;
        ex[i] = rx;
        ey[i] = ry;
        ez[i] = rz;
    endtask

    task automatic drive_vec(input int i);
        screen_x       = vx[i];
        screen_y       = vy[i];
        camera_forward = vf[i];
        valid_in       = 1'b1;
    endtask

    task automatic check_ray(input string tag, input int i, input longint tol);
        real rx, ry, rz, m;
        check_val({tag, ".x"}, longint'(ray_direction.x), q24(ex[i]), tol);
        check_val({tag, ".y"}, longint'(ray_direction.y), q24(ey[i]), tol);
        check_val({tag, ".z"}, longint'(ray_direction.z), q24(ez[i]), tol);
        rx = $itor(ray_direction.x) / 16777216.0;
        ry = $itor(ray_direction.y) / 16777216.0;
        rz = $itor(ray_direction.z) / 16777216.0;
        m  = $sqrt(rx * rx + ry * ry + rz * rz);
        check_val({tag, ".mag"}, q24(m), 64'sd16777216, 8192);
    endtask

    task automatic run_single(input int i);
        int    cyc;
        string tag;
        tag = $sformatf("vec%0d", i);
        @(negedge clk);
        drive_vec(i);
        @(negedge clk);
        valid_in = 1'b0;
        cyc = 1;
        while (!valid_out && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, ".latency"}, cyc, 8, 0);
        check_ray(tag, i, (i == 7) ? 0 : 4096);
        @(negedge clk);
        check_val({tag, ".pulse"}, longint'(valid_out), 0, 0);
        repeat (2) @(negedge clk);
        check_ray({tag, ".held"}, i, (i == 7) ? 0 : 4096);
    endtask

    task automatic run_back_to_back();
        int k;
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (valid_out) begin
                if (k < 6) begin
                    check_val($sformatf("b2b%0d.cycle", k), cyc, 8 + k, 0);
                    check_ray($sformatf("b2b%0d", k), k, 4096);
                end
                k++;
            end
            if (cyc < 6) begin
                drive_vec(cyc);
            end else begin
                valid_in = 1'b0;
            end
        end
        check_val("b2b.count", k, 6, 0);
    endtask

    task automatic run_reset_midflight();
        int stale;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                drive_vec(cyc);
            end else begin
                valid_in = 1'b0;
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst.valid_out", longint'(valid_out), 0, 0);
        check_val("rst.ray.x", longint'(ray_direction.x), 0, 0);
        check_val("rst.ray.y", longint'(ray_direction.y), 0, 0);
        check_val("rst.ray.z", longint'(ray_direction.z), 0, 0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid_out) stale++;
        end
        check_val("rst.stale_outputs", stale, 0, 0);
        check_val("rst.after.z", longint'(ray_direction.z), 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_vec(0, 32'h0000_0000, 32'h0000_0000, mk_vec(32'sh0, 32'sh0, FP_ONE), -0.6859943,  0.5144958, 0.5144958);
        set_vec(1, 32'h5000_0000, 32'h0000_0000, mk_vec(32'sh0, 32'sh0, FP_ONE),  0.6859943,  0.5144958, 0.5144958);
        set_vec(2, 32'h5000_0000, 32'h3c00_0000, mk_vec(32'sh0, 32'sh0, FP_ONE),  0.6859943, -0.5144958, 0.5144958);
        set_vec(3, 32'h0000_0000, 32'h3c00_0000, mk_vec(32'sh0, 32'sh0, FP_ONE), -0.6859943, -0.5144958, 0.5144958);
        set_vec(4, 32'h2800_0000, 32'h1e00_0000, mk_vec(32'sh0, 32'sh0, FP_ONE),  0.0,        0.0,       1.0);
        set_vec(5, 32'h2800_0000, 32'h0000_0000, mk_vec(32'sh0, 32'sh0, FP_ONE),  0.0,        0.7071068, 0.7071068);
        set_vec(6, 32'h7800_0000, 32'h1e00_0000, mk_vec(32'sh0, 32'sh0, FP_ONE),  0.9363292,  0.0,       0.3511234);
        set_vec(7, 32'h0000_0000, 32'h0000_0000, mk_vec(32'sh0155_5555, 32'shff00_0000, 32'sh0), 0.0, 0.0, 1.0);
        set_vec(8, 32'h2800_0000, 32'h1e00_0000, mk_vec(FP_ONE, 32'sh0, 32'sh0),  1.0,        0.0,       0.0);

        repeat (3) @(negedge clk);
        check_val("reset.valid_out", longint'(valid_out), 0, 0);
        check_val("reset.ray.x", longint'(ray_direction.x), 0, 0);
        check_val("reset.ray.y", longint'(ray_direction.y), 0, 0);
        check_val("reset.ray.z", longint'(ray_direction.z), 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_single(i);
        end
        run_back_to_back();
        run_reset_midflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
